gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Sequencer that drives a 2-input logic gate under test (NOR, AND, etc.) through all four input combinations, holds each for a programmable number of cycles, samples the gate output, and compares the captured truth table against an expected one. It sits between a test/config master (start/done handshake) and a single combinational gate instance. It replaces hand-written timed stimulus with a synthesizable, self-checking sweep.

## Interface
Parameters:
- HOLD_CYCLES, 20: cycles each input combination is held; legal range ≥1.
- CNT_W, $clog2(HOLD_CYCLES+1): width of the hold counter.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a sweep; sampled only in IDLE.
- exp_tt, input, 4: expected truth table, latched when start is accepted. Bit index = {A,B}; NOR = 4'b0001.
- gate_a, output, 1: A input to the gate under test.
- gate_b, output, 1: B input to the gate under test.
- gate_o, input, 1: gate output, combinational from gate_a/gate_b.
- busy, output, 1: high while a sweep is in progress.
- done, output, 1: one-cycle pulse when a sweep completes.
- pass, output, 1: captured table equals latched expectation.
- tt, output, 4: captured truth table; tt[{A,B}] = sampled gate_o.
- mismatch, output, 4: tt XOR latched exp_tt.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - gate_a = gate_b = 0 and busy = 0.
  - On start = 1: latch exp_tt, set idx = 0 and cnt = 0, clear tt/pass/mismatch to 0, then go to DRIVE.
- DRIVE:
  - {gate_a, gate_b} = idx[1:0] and busy = 1.
  - cnt increments every cycle.
  - When cnt == HOLD_CYCLES-1: register gate_o into tt[idx] and reset cnt to 0.
  - After that sample, if idx == 3 go to DONE; otherwise increment idx and stay in DRIVE.
- DONE (one cycle):
  - done = 1, busy = 0, gate inputs return to 0.
  - pass and mismatch are registered here from tt and the latched exp_tt.
  - Unconditionally return to IDLE.
- tt, pass and mismatch hold their values until the next accepted start or reset.
- start is ignored in DRIVE and DONE. No queuing.
- Reset values (all outputs): gate_a = 0, gate_b = 0, busy = 0, done = 0, pass = 0, tt = 4'b0000, mismatch = 4'b0000. State = IDLE, idx = 0, cnt = 0.
- Reset mid-sweep: the sweep is abandoned, all outputs go to their reset values on the next edge, and no done is issued.
- Combination order is fixed: 00, 01, 10, 11 (A is the MSB).
- idx is 2 bits. It never wraps inside a sweep, because DONE is entered at idx == 3.

## Timing
- Let cycle 0 be the cycle where start = 1 is sampled in IDLE.
- Combination i is driven in cycles i·HOLD_CYCLES+1 through (i+1)·HOLD_CYCLES.
- gate_o is sampled on the last cycle of each combination, giving HOLD_CYCLES-1 settle cycles.
- busy is high in cycles 1 through 4·HOLD_CYCLES.
- done and the final pass/mismatch are visible in cycle 4·HOLD_CYCLES+1.
- IDLE is re-entered in cycle 4·HOLD_CYCLES+2. A held start is accepted there, so back-to-back sweeps are separated by one IDLE cycle.
- Sweep latency from start to done = 4·HOLD_CYCLES+1 cycles.
- HOLD_CYCLES = 1: the counter is degenerate, each combination lasts one cycle, and done appears in cycle 5.

## Test plan
- NOR instance, HOLD_CYCLES = 2, exp_tt = 4'b0001, start pulsed in cycle 0:
  - gate_a/gate_b read 00,00,01,01,10,10,11,11 in cycles 1–8.
  - done = 1 in cycle 9 with tt = 0001, pass = 1, mismatch = 0000.
- gate_o tied to 1, exp_tt = 4'b0001: tt = 1111, mismatch = 1110, pass = 0, done in cycle 4·HOLD_CYCLES+1.
- AND instance, exp_tt = 4'b1000, start re-pulsed in cycles 3 and 6 during the sweep:
  - The extra pulses are ignored, exactly one done is produced, and pass = 1.
- HOLD_CYCLES = 2, rst asserted in cycle 5:
  - In cycle 6 all outputs read their reset values and no done follows.
  - A new start restarts from combination 00 with tt cleared.
- HOLD_CYCLES = 1, start held high continuously:
  - done pulses in cycles 5, 11, 17 and so on; busy is low in each done cycle and in the following IDLE cycle.
- exp_tt changed during a sweep: the result is compared against the value latched at start, not the new input value.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps a 2-input gate through 00,01,10,11 and checks its truth table
// Holds each combination HOLD_CYCLES cycles and samples gate_o on the last one.
module gate_sweep_ctrl #(
  parameter int HOLD_CYCLES = 20,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exp_tt,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] tt,
  output logic [3:0] mismatch
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       exp_q;
  logic [3:0]       tt_q;
  logic             pass_q;
  logic [3:0]       mismatch_q;
  logic [3:0]       tt_d;
  logic             last_hold;

  assign last_hold = (cnt_q == CNT_LAST);

  always_comb begin
    tt_d        = tt_q;
    tt_d[idx_q] = gate_o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_DRIVE;
      S_DRIVE: if (last_hold && (idx_q == 2'd3)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gate_a = 1'b0;
    gate_b = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      S_DRIVE: begin
        {gate_a, gate_b} = idx_q;
        busy             = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // The verdict is formed from the final sample on the edge into DONE so that
  // it is already visible alongside the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      exp_q      <= 4'd0;
      tt_q       <= 4'd0;
      pass_q     <= 1'b0;
      mismatch_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            exp_q      <= exp_tt;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            tt_q       <= 4'd0;
            pass_q     <= 1'b0;
            mismatch_q <= 4'd0;
          end
        end
        S_DRIVE: begin
          if (last_hold) begin
            cnt_q <= '0;
            tt_q  <= tt_d;
            if (idx_q == 2'd3) begin
              pass_q     <= (tt_d == exp_q);
              mismatch_q <= tt_d ^ exp_q;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE:  idx_q <= 2'd0;
        default: ;
      endcase
    end
  end

  assign tt       = tt_q;
  assign pass     = pass_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - self-checking bench for gate_sweep_ctrl
// Two instances: HOLD_CYCLES=2 for sweep scenarios, HOLD_CYCLES=1 for back-to-back.
module tb_gate_sweep_ctrl;

  localparam int HA = 2;
  localparam int HB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       rst_a, start_a, ga_a, gb_a, go_a, busy_a, done_a, pass_a;
  logic [3:0] exp_a, gtt_a, tt_a, mm_a;
  logic [1:0] sel_a;
  logic       rst_b, start_b, ga_b, gb_b, go_b, busy_b, done_b, pass_b;
  logic [3:0] exp_b, gtt_b, tt_b, mm_b;
  logic [1:0] sel_b;

  // Gate under test modelled as a lookup of its truth table.
  assign sel_a = {ga_a, gb_a};
  assign go_a  = gtt_a[sel_a];
  assign sel_b = {ga_b, gb_b};
  assign go_b  = gtt_b[sel_b];

  gate_sweep_ctrl #(.HOLD_CYCLES(HA)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .exp_tt(exp_a),
    .gate_a(ga_a), .gate_b(gb_a), .gate_o(go_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .tt(tt_a), .mismatch(mm_a)
  );

  gate_sweep_ctrl #(.HOLD_CYCLES(HB)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .exp_tt(exp_b),
    .gate_a(ga_b), .gate_b(gb_b), .gate_o(go_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .tt(tt_b), .mismatch(mm_b)
  );

  // One full sweep on dut_a, every cycle compared against the timing rules.
  task automatic do_sweep_a(input string name, input logic [3:0] gtt, input logic [3:0] exp,
                            input bit extra_starts, input bit wiggle_exp);
    logic [3:0] exp_ref, tt_ref, mm_ref;
    logic [1:0] sel_ref;
    logic       busy_ref, done_ref, pass_ref;
    int         last, dones;
    last  = 4 * HA + 1;
    dones = 0;
    @(negedge clk);
    gtt_a   = gtt;
    exp_a   = exp;
    exp_ref = exp;
    start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= last + 4; c++) begin
      @(negedge clk);
      busy_ref = (c <= 4 * HA);
      done_ref = (c == last);
      sel_ref  = busy_ref ? 2'((c - 1) / HA) : 2'd0;
      tt_ref   = 4'd0;
      for (int i = 0; i < 4; i++) if ((i + 1) * HA + 1 <= c) tt_ref[i] = gtt[i];
      pass_ref = (c >= last) ? (gtt == exp_ref) : 1'b0;
      mm_ref   = (c >= last) ? (gtt ^ exp_ref) : 4'd0;
      if (done_a === 1'b1) dones++;
      n_checks++;
      if ({busy_a, done_a, sel_a} !== {busy_ref, done_ref, sel_ref}) begin
        n_fail++;
        $display("FAIL %s cyc%0d busy/done/ab: got %b expected %b", name, c,
                 {busy_a, done_a, sel_a}, {busy_ref, done_ref, sel_ref});
      end
      n_checks++;
      if (tt_a !== tt_ref) begin
        n_fail++;
        $display("FAIL %s cyc%0d tt: got %b expected %b", name, c, tt_a, tt_ref);
      end
      n_checks++;
      if ({pass_a, mm_a} !== {pass_ref, mm_ref}) begin
        n_fail++;
        $display("FAIL %s cyc%0d pass/mm: got %b expected %b", name, c,
                 {pass_a, mm_a}, {pass_ref, mm_ref});
      end
      start_a = extra_starts && (c == 3 || c == 6);
      if (wiggle_exp) exp_a = 4'($urandom);
    end
    start_a = 1'b0;
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL %s done count: got %0d expected 1", name, dones);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; start_a = 1'b0; exp_a = 4'd0; gtt_a = 4'd0;
    rst_b = 1'b1; start_b = 1'b0; exp_b = 4'd0; gtt_b = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ga_a, gb_a, busy_a, done_a, pass_a, tt_a, mm_a} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_a: got %b expected 0", {ga_a, gb_a, busy_a, done_a, pass_a, tt_a, mm_a});
    end
    n_checks++;
    if ({ga_b, gb_b, busy_b, done_b, pass_b, tt_b, mm_b} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_b: got %b expected 0", {ga_b, gb_b, busy_b, done_b, pass_b, tt_b, mm_b});
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  task automatic test_nor();
    do_sweep_a("nor", 4'b0001, 4'b0001, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_high();
    do_sweep_a("stuck1", 4'b1111, 4'b0001, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_sweep_a("and_restart", 4'b1000, 4'b1000, 1'b1, 1'b0);
  endtask

  task automatic test_exp_change();
    logic [3:0] g;
    g = 4'($urandom);
    do_sweep_a("exp_change", g, g, 1'b0, 1'b1);
    do_sweep_a("exp_change_bad", g, ~g, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    int dones;
    dones = 0;
    @(negedge clk);
    gtt_a = 4'b0001; exp_a = 4'b0001; start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ga_a, gb_a, busy_a, done_a, pass_a, tt_a, mm_a} !== 13'd0) begin
      n_fail++;
      $display("FAIL mid_reset cyc6: got %b expected 0", {ga_a, gb_a, busy_a, done_a, pass_a, tt_a, mm_a});
    end
    rst_a = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || busy_a !== 1'b0) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL mid_reset activity after reset: got %0d cycles expected 0", dones);
    end
    do_sweep_a("after_reset", 4'b0001, 4'b0001, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] g, e;
    for (int n = 0; n < 6; n++) begin
      g = 4'($urandom);
      e = ($urandom_range(0, 1) == 1) ? g : 4'($urandom);
      do_sweep_a("random", g, e, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sel_ref;
    logic       busy_ref, done_ref;
    logic [3:0] e;
    int         ph, dones;
    dones = 0;
    @(negedge clk);
    gtt_b   = 4'($urandom);
    e       = gtt_b ^ 4'($urandom_range(0, 1) << $urandom_range(0, 3));
    exp_b   = e;
    start_b = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      ph       = c % 6;
      busy_ref = (ph >= 1 && ph <= 4);
      done_ref = (ph == 5);
      sel_ref  = busy_ref ? 2'(ph - 1) : 2'd0;
      if (done_b === 1'b1) dones++;
      n_checks++;
      if ({busy_b, done_b, sel_b} !== {busy_ref, done_ref, sel_ref}) begin
        n_fail++;
        $display("FAIL b2b cyc%0d busy/done/ab: got %b expected %b", c,
                 {busy_b, done_b, sel_b}, {busy_ref, done_ref, sel_ref});
      end
      if (done_ref) begin
        n_checks++;
        if ({tt_b, pass_b, mm_b} !== {gtt_b, gtt_b == e, gtt_b ^ e}) begin
          n_fail++;
          $display("FAIL b2b cyc%0d result: got %b expected %b", c,
                   {tt_b, pass_b, mm_b}, {gtt_b, gtt_b == e, gtt_b ^ e});
        end
      end
    end
    start_b = 1'b0;
    n_checks++;
    if (dones != 4) begin
      n_fail++;
      $display("FAIL b2b done count: got %0d expected 4", dones);
    end
  endtask

  initial begin
    test_reset();
    test_nor();
    test_stuck_high();
    test_ignore_start();
    test_exp_change();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
